// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder.
// Accepts symbolic requests over a valid/ready handshake, assembles each one into
// a 32-bit MIPS word and writes the words one after another into instruction
// memory, starting at BASE_ADDR. Each request takes three cycles:
// accept (IDLE) -> encode (ENC) -> write strobe (WR).
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              full,
  output logic              err_illegal
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned FUN_W  = 6;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  // Number of words the memory holds; prog_len saturates here.
  localparam logic [LEN_W-1:0] CAPACITY = LEN_W'(1) << ADDR_W;

  // Symbolic operation codes on in_op.
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd4;
  localparam logic [OP_W-1:0] OP_ADDI = 4'd5;
  localparam logic [OP_W-1:0] OP_LW   = 4'd6;
  localparam logic [OP_W-1:0] OP_SW   = 4'd7;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'd8;
  localparam logic [OP_W-1:0] OP_J    = 4'd9;

  // MIPS primary opcodes (bits 31:26).
  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;

  // R-type function codes (bits 5:0).
  localparam logic [FUN_W-1:0] FUN_ADD = 6'b100000;
  localparam logic [FUN_W-1:0] FUN_SUB = 6'b100010;
  localparam logic [FUN_W-1:0] FUN_AND = 6'b100100;
  localparam logic [FUN_W-1:0] FUN_OR  = 6'b100101;
  localparam logic [FUN_W-1:0] FUN_SLT = 6'b101010;

  localparam logic [REG_W-1:0] SHAMT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Request fields captured at the handshake.
  logic [OP_W-1:0]   op_q,  op_d;
  logic [REG_W-1:0]  rs_q,  rs_d;
  logic [REG_W-1:0]  rt_q,  rt_d;
  logic [REG_W-1:0]  rd_q,  rd_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d;

  // Memory-side and status registers.
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic              full_q,  full_d;
  logic              err_q,   err_d;

  logic              accept;
  logic              op_legal;
  logic [WORD_W-1:0] enc_word;
  logic [LEN_W-1:0]  len_inc;

  // Ready only when idle with room left; clear and reset both block the handshake.
  assign in_ready = rst && (state_q == S_IDLE) && !full_q && !clear;
  assign accept   = in_valid && in_ready;
  assign len_inc  = len_q + LEN_W'(1);

  // Build the MIPS word from the captured fields; unknown ops flag illegal.
  always_comb begin
    op_legal = 1'b1;
    enc_word = '0;
    case (op_q)
      OP_ADD:  enc_word = {OPC_RTYPE, rs_q, rt_q, rd_q, SHAMT_ZERO, FUN_ADD};
      OP_SUB:  enc_word = {OPC_RTYPE, rs_q, rt_q, rd_q, SHAMT_ZERO, FUN_SUB};
      OP_AND:  enc_word = {OPC_RTYPE, rs_q, rt_q, rd_q, SHAMT_ZERO, FUN_AND};
      OP_OR:   enc_word = {OPC_RTYPE, rs_q, rt_q, rd_q, SHAMT_ZERO, FUN_OR};
      OP_SLT:  enc_word = {OPC_RTYPE, rs_q, rt_q, rd_q, SHAMT_ZERO, FUN_SLT};
      OP_ADDI: enc_word = {OPC_ADDI, rs_q, rt_q, imm_q};
      OP_LW:   enc_word = {OPC_LW,   rs_q, rt_q, imm_q};
      OP_SW:   enc_word = {OPC_SW,   rs_q, rt_q, imm_q};
      OP_BEQ:  enc_word = {OPC_BEQ,  rs_q, rt_q, imm_q};
      OP_J:    enc_word = {OPC_J, tgt_q};
      default: op_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear wins over everything else.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_ENC;
        S_ENC:   state_d = op_legal ? S_WR : S_IDLE;
        S_WR:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values: capture, encode, then commit the write.
  always_comb begin
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    tgt_d   = tgt_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    ptr_d   = ptr_q;
    len_d   = len_q;
    full_d  = full_q;
    err_d   = err_q;
    if (clear) begin
      ptr_d  = BASE_ADDR;
      len_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d  = in_op;
            rs_d  = in_rs;
            rt_d  = in_rt;
            rd_d  = in_rd;
            imm_d = in_imm;
            tgt_d = in_target;
          end
        end
        S_ENC: begin
          wdata_d = enc_word;
          if (op_legal) begin
            we_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        S_WR: begin
          // The strobe has been high for a full cycle; advance to the next slot.
          if (len_q != CAPACITY) begin
            len_d  = len_inc;
            ptr_d  = ptr_q + ADDR_W'(1);
            full_d = (len_inc == CAPACITY);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      tgt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ptr_q   <= BASE_ADDR;
      len_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      tgt_q   <= tgt_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign prog_len    = len_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule
